led_matrix_column_scanner: RTL and testbench

LED_MATRIX_COLUMN_SCANNER -- requirements
Module: led_matrix_column_scanner

---
 rtl/led_matrix_column_scanner_pkg.sv | 34 +++
 rtl/led_matrix_tick_divider.sv | 38 +++
 rtl/led_matrix_column_scanner.sv | 109 ++++++++++
 tb/tb_led_matrix_column_scanner.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/led_matrix_column_scanner_pkg.sv
// ============================================================================
//  Module      : led_matrix_column_scanner_pkg
//  Description : Shared geometry constants, column index type and the
//                column-slice macro for the led_matrix blocks.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

// Selects the 7-bit image of column c out of a packed frame word.
`ifndef LED_MATRIX_COL_SLICE
`define LED_MATRIX_COL_SLICE(c) ((c) * led_matrix_column_scanner_pkg::NUM_ROWS) +: led_matrix_column_scanner_pkg::NUM_ROWS
`endif

package led_matrix_column_scanner_pkg;

    localparam int NUM_COLS = 5;
    localparam int NUM_ROWS = 7;
    localparam int FRAME_W  = NUM_COLS * NUM_ROWS;
    localparam int COL_W    = 3;

    typedef logic [COL_W-1:0] col_idx_t;

    localparam col_idx_t            LAST_COL = col_idx_t'(NUM_COLS - 1);
    localparam logic [NUM_COLS-1:0] COL_ONE  = NUM_COLS'(1);

    // Next column index with wrap from the last column back to column 0.
    function automatic col_idx_t next_col(input col_idx_t c);
        return (c == LAST_COL) ? '0 : c + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/led_matrix_tick_divider.sv
// ============================================================================
//  Module      : led_matrix_tick_divider
//  Description : Free-running prescaler 0..DIV-1; tick is high on the cycle
//                the count sits at DIV-1.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module led_matrix_tick_divider #(
    parameter int DIV = 10000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int               CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_count;

    // Prescaler count with wrap at DIV-1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tick = (r_count == LAST);

endmodule

`default_nettype wire

// File: rtl/led_matrix_column_scanner.sv
// ============================================================================
//  Module      : led_matrix_column_scanner
//  Description : 5x7 LED matrix column scanner with double-buffered frame
//                image, tear-free swap at frame wrap and frame-rate blink.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module led_matrix_column_scanner
    import led_matrix_column_scanner_pkg::*;
#(
    parameter int DIV          = 10000,
    parameter int BLINK_FRAMES = 250
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [FRAME_W-1:0]  frame_data,
    input  logic                frame_load,
    input  logic                blink_en,
    output logic [NUM_COLS-1:0] columns_n,
    output logic [NUM_ROWS-1:0] rows_n,
    output logic                frame_done
);

    localparam int            BLINK_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    logic                w_tick;
    logic                w_wrap;
    col_idx_t            r_col;
    logic [FRAME_W-1:0]  r_display;
    logic [FRAME_W-1:0]  r_pending;
    logic                r_pending_valid;
    logic [BLINK_W-1:0]  r_blink_cnt;
    logic                r_blink_phase;

    led_matrix_tick_divider #(
        .DIV (DIV)
    ) u_tick_divider (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    // Last slot of the last column: the only point the frame may change.
    assign w_wrap = w_tick && (r_col == LAST_COL);

    // Column index advances once per slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col <= '0;
        end else if (w_tick) begin
            r_col <= next_col(r_col);
        end
    end

    // Double buffer: loads park in pending and are promoted only at wrap;
    // a load landing exactly on the wrap goes straight to display.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_display       <= '0;
            r_pending       <= '0;
            r_pending_valid <= 1'b0;
        end else if (w_wrap) begin
            if (frame_load) begin
                r_display <= frame_data;
            end else if (r_pending_valid) begin
                r_display <= r_pending;
            end
            r_pending_valid <= 1'b0;
        end else if (frame_load) begin
            r_pending       <= frame_data;
            r_pending_valid <= 1'b1;
        end
    end

    // Blink phase flips every BLINK_FRAMES completed frames.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_wrap) begin
            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    // Registered active-low drivers; rows blank during the off blink phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            columns_n  <= '1;
            rows_n     <= '1;
            frame_done <= 1'b0;
        end else begin
            columns_n  <= ~(COL_ONE << r_col);
            rows_n     <= (blink_en && r_blink_phase) ? '1
                                                      : ~r_display[`LED_MATRIX_COL_SLICE(r_col)];
            frame_done <= w_wrap;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_led_matrix_column_scanner.sv
// ============================================================================
//  Module      : tb_led_matrix_column_scanner
//  Description : Directed table-driven bench for led_matrix_column_scanner
//                with DIV=4, BLINK_FRAMES=2.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_led_matrix_column_scanner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [34:0] frame_data = '0;
    logic        frame_load = 1'b0;
    logic        blink_en = 1'b0;
    logic [4:0]  columns_n;
    logic [6:0]  rows_n;
    logic        frame_done;

    localparam logic [34:0] ONES = {35{1'b1}};

    int tests  = 0;
    int failed = 0;
    int cur    = 0;   // rising edges since reset release

    typedef struct {
        int          cyc;
        logic        load;
        logic [34:0] data;
        logic        blink;
        logic [4:0]  cols;
        logic [6:0]  rows;
        logic        done;
    } vec_t;

    vec_t vq[$];

    led_matrix_column_scanner #(
        .DIV          (4),
        .BLINK_FRAMES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_data (frame_data),
        .frame_load (frame_load),
        .blink_en   (blink_en),
        .columns_n  (columns_n),
        .rows_n     (rows_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic edge_step();
        @(posedge clk);
        #1;
        cur++;
    endtask

    task automatic check(input string name, input logic [4:0] ec,
                         input logic [6:0] er, input logic ed);
        tests++;
        if ({columns_n, rows_n, frame_done} !== {ec, er, ed}) begin
            failed++;
            $display("FAIL %s: got cols=%b rows=%h done=%b, expected cols=%b rows=%h done=%b",
                     name, columns_n, rows_n, frame_done, ec, er, ed);
        end
    endtask

    task automatic add(input int c, input logic ld, input logic [34:0] d,
                       input logic bl, input logic [4:0] ec,
                       input logic [6:0] er, input logic ed);
        vec_t v;
        v.cyc = c; v.load = ld; v.data = d; v.blink = bl;
        v.cols = ec; v.rows = er; v.done = ed;
        vq.push_back(v);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; frame_load = 1'b0; blink_en = 1'b0;
        edge_step();
        edge_step();
        check("reset", 5'b11111, 7'h7F, 1'b0);
        rst_n = 1'b1;
        cur = 0;
    endtask

    // Each vector drives its inputs into edge cyc and checks right after it.
    task automatic run_vectors(input string tag);
        foreach (vq[i]) begin
            while (cur < vq[i].cyc - 1) begin
                frame_load = 1'b0;
                blink_en   = vq[i].blink;
                edge_step();
            end
            frame_load = vq[i].load;
            frame_data = vq[i].data;
            blink_en   = vq[i].blink;
            edge_step();
            frame_load = 1'b0;
            check($sformatf("%s@%0d", tag, vq[i].cyc), vq[i].cols, vq[i].rows, vq[i].done);
        end
        vq.delete();
    endtask

    initial begin
        // Scan timing, pending load, bypass load at wrap, last-load-wins.
        do_reset();
        add( 1, 0, '0,     0, 5'b11110, 7'h7F, 0);
        add( 4, 0, '0,     0, 5'b11110, 7'h7F, 0);
        add( 5, 0, '0,     0, 5'b11101, 7'h7F, 0);
        add( 9, 0, '0,     0, 5'b11011, 7'h7F, 0);
        add(10, 1, ONES,   0, 5'b11011, 7'h7F, 0);
        add(13, 0, '0,     0, 5'b10111, 7'h7F, 0);
        add(17, 0, '0,     0, 5'b01111, 7'h7F, 0);
        add(20, 0, '0,     0, 5'b01111, 7'h7F, 1);
        add(21, 0, '0,     0, 5'b11110, 7'h00, 0);
        add(25, 0, '0,     0, 5'b11101, 7'h00, 0);
        add(37, 0, '0,     0, 5'b01111, 7'h00, 0);
        add(40, 1, 35'h55, 0, 5'b01111, 7'h00, 1);
        add(41, 0, '0,     0, 5'b11110, 7'h2A, 0);
        add(45, 0, '0,     0, 5'b11101, 7'h7F, 0);
        add(50, 1, 35'h01, 0, 5'b11011, 7'h7F, 0);
        add(55, 1, 35'h02, 0, 5'b10111, 7'h7F, 0);
        add(60, 0, '0,     0, 5'b01111, 7'h7F, 1);
        add(61, 0, '0,     0, 5'b11110, 7'h7D, 0);
        add(81, 0, '0,     0, 5'b11110, 7'h7D, 0);
        run_vectors("scan");

        // Blink: phase flips every second wrap; columns keep scanning.
        do_reset();
        add(  1, 1, ONES, 1, 5'b11110, 7'h7F, 0);
        add( 22, 0, '0,   1, 5'b11110, 7'h00, 0);
        add( 42, 0, '0,   1, 5'b11110, 7'h7F, 0);
        add( 46, 0, '0,   1, 5'b11101, 7'h7F, 0);
        add( 62, 0, '0,   1, 5'b11110, 7'h7F, 0);
        add( 82, 0, '0,   1, 5'b11110, 7'h00, 0);
        add(102, 0, '0,   1, 5'b11110, 7'h00, 0);
        add(122, 0, '0,   1, 5'b11110, 7'h7F, 0);
        add(126, 0, '0,   0, 5'b11101, 7'h00, 0);
        run_vectors("blink");

        // Reset in column 3 with a pending frame and a load during reset.
        do_reset();
        add( 1, 1, ONES,  0, 5'b11110, 7'h7F, 0);
        add(25, 1, 35'h1, 0, 5'b11101, 7'h00, 0);
        add(32, 0, '0,    0, 5'b11011, 7'h00, 0);
        run_vectors("pre_rst");
        rst_n = 1'b0; frame_load = 1'b1; frame_data = ONES;
        edge_step();
        check("mid_rst", 5'b11111, 7'h7F, 1'b0);
        rst_n = 1'b1; frame_load = 1'b0;
        cur = 0;
        add( 1, 0, '0, 0, 5'b11110, 7'h7F, 0);
        add( 4, 0, '0, 0, 5'b11110, 7'h7F, 0);
        add( 5, 0, '0, 0, 5'b11101, 7'h7F, 0);
        add(20, 0, '0, 0, 5'b01111, 7'h7F, 1);
        add(21, 0, '0, 0, 5'b11110, 7'h7F, 0);
        run_vectors("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
